// File: rtl/matrix_bank_pkg.sv
// Shared types and sizing for the matrix bank fetch path.
package matrix_bank_pkg;

    localparam int unsigned MAX_FETCH_REQ_BYTE_COUNT = 4096;
    localparam int unsigned BCW = $clog2(MAX_FETCH_REQ_BYTE_COUNT);

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } ARB_FSM_e;

    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/owner_fifo.sv
// In-order record of which bank owns each accepted-but-incomplete fetch.
module owner_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     core_clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/matrix_bank_fetch_arbiter.sv
// Round-robin sharing of one AXI read master among matrix banks, with
// in-order routing of read beats back to the issuing bank.
module matrix_bank_fetch_arbiter
    import matrix_bank_pkg::*;
#(
    parameter int unsigned NUM_BANKS         = 4,
    parameter int unsigned AXI_ADDRESS_WIDTH = 34,
    parameter int unsigned AXI_DATA_WIDTH    = 512,
    parameter int unsigned MAX_OUTSTANDING   = 4
) (
    input  logic                                        core_clk,
    input  logic                                        resetn,
    input  logic [NUM_BANKS-1:0]                        bank_fetch_req_valid,
    output logic [NUM_BANKS-1:0]                        bank_fetch_req_ready,
    input  logic [NUM_BANKS-1:0][AXI_ADDRESS_WIDTH-1:0] bank_fetch_start_address,
    input  logic [NUM_BANKS-1:0][BCW-1:0]               bank_fetch_byte_count,
    output logic                                        axi_rm_fetch_req_valid,
    input  logic                                        axi_rm_fetch_req_ready,
    output logic [AXI_ADDRESS_WIDTH-1:0]                axi_rm_fetch_start_address,
    output logic [BCW-1:0]                              axi_rm_fetch_byte_count,
    input  logic                                        axi_rm_fetch_resp_valid,
    output logic                                        axi_rm_fetch_resp_ready,
    input  logic                                        axi_rm_fetch_resp_last,
    input  logic [AXI_DATA_WIDTH-1:0]                   axi_rm_fetch_resp_data,
    input  logic [3:0]                                  axi_rm_fetch_resp_axi_id,
    output logic [NUM_BANKS-1:0]                        bank_fetch_resp_valid,
    input  logic [NUM_BANKS-1:0]                        bank_fetch_resp_ready,
    output logic                                        bank_fetch_resp_last,
    output logic [AXI_DATA_WIDTH-1:0]                   bank_fetch_resp_data,
    output logic [3:0]                                  bank_fetch_resp_axi_id,
    output logic [$clog2(MAX_OUTSTANDING):0]            outstanding_count,
    output logic                                        unexpected_resp
);

    localparam int unsigned IW = $clog2(NUM_BANKS);
    localparam logic [NUM_BANKS-1:0] ONE = {{(NUM_BANKS-1){1'b0}}, 1'b1};

    ARB_FSM_e                     r_state;
    logic [IW-1:0]                r_rr_ptr;
    logic [IW-1:0]                r_grant;
    logic [AXI_ADDRESS_WIDTH-1:0] r_addr;
    logic [BCW-1:0]               r_bc;
    logic                         r_req_valid;
    logic                         r_unexpected;

    logic          w_sel_found;
    logic [IW-1:0] w_sel_idx;
    logic [IW-1:0] w_k;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;
    logic [IW-1:0] w_head;
    logic          w_empty;
    logic          w_full;

    // First valid bank at or after the round-robin pointer, searching with wrap.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_k         = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            w_k = IW'(wrap_add(32'(r_rr_ptr), i, NUM_BANKS));
            if (!w_sel_found && bank_fetch_req_valid[w_k]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_k;
            end
        end
    end

    assign w_grant              = (r_state == ARB_IDLE) & w_sel_found & ~w_full;
    assign bank_fetch_req_ready = w_grant ? (ONE << w_sel_idx) : '0;
    assign w_push               = r_req_valid & axi_rm_fetch_req_ready;

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_addr      <= '0;
            r_bc        <= '0;
            r_req_valid <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant) begin
                        r_grant     <= w_sel_idx;
                        r_addr      <= bank_fetch_start_address[w_sel_idx];
                        r_bc        <= bank_fetch_byte_count[w_sel_idx];
                        r_req_valid <= 1'b1;
                        r_state     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (axi_rm_fetch_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_rr_ptr    <= (r_grant == IW'(NUM_BANKS-1)) ? '0 : r_grant + 1'b1;
                        r_state     <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    assign axi_rm_fetch_req_valid     = r_req_valid;
    assign axi_rm_fetch_start_address = r_addr;
    assign axi_rm_fetch_byte_count    = r_bc;

    owner_fifo #(
        .WIDTH (IW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .core_clk    (core_clk),
        .resetn      (resetn),
        .i_push      (w_push),
        .i_push_data (r_grant),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (outstanding_count),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

    // Response path is pure steering toward the owner at the FIFO head.
    assign bank_fetch_resp_valid   = (axi_rm_fetch_resp_valid & ~w_empty) ? (ONE << w_head) : '0;
    assign axi_rm_fetch_resp_ready = bank_fetch_resp_ready[w_head] & ~w_empty;
    assign w_pop                   = axi_rm_fetch_resp_valid & axi_rm_fetch_resp_ready
                                     & axi_rm_fetch_resp_last;
    assign bank_fetch_resp_last    = axi_rm_fetch_resp_last;
    assign bank_fetch_resp_data    = axi_rm_fetch_resp_data;
    assign bank_fetch_resp_axi_id  = axi_rm_fetch_resp_axi_id;

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) r_unexpected <= 1'b0;
        else         r_unexpected <= r_unexpected | (axi_rm_fetch_resp_valid & w_empty);
    end

    assign unexpected_resp = r_unexpected;

endmodule
